e_mdu: RTL and testbench

Execute-stage multiply/divide unit for the pipelined MIPS core, sitting beside the ALU and fed the same forwarded E-stage operands. It executes mult/multu/div/divu as multi-cycle operations against private HI/LO registers, handles mthi/mtlo/mfhi/mflo, and exports a busy flag that the hazard unit uses to stall MDU instructions in D. An exception/interrupt request cancels the E-stage instruction's effect on HI/LO, matching precise-exception rules.

---
 rtl/e_mdu_pkg.sv | 24 ++
 rtl/e_mdu.sv | 122 ++++++++++++
 tb/tb_e_mdu.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/e_mdu_pkg.sv
// e_mdu_pkg: shared op codes, default cycle counts and op classification for the MDU.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package e_mdu_pkg;

   localparam logic [3:0] OP_NONE  = 4'd0;
   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
   localparam logic [3:0] OP_MFHI  = 4'd7;
   localparam logic [3:0] OP_MFLO  = 4'd8;

   localparam int MULT_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF  = 10;

   // Ops that launch a multi-cycle operation (the hazard unit stalls on these in E).
   function automatic logic is_start_op(input logic [3:0] op);
      return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/e_mdu.sv
// e_mdu: E-stage multiply/divide unit with private HI/LO, mthi/mtlo/mfhi/mflo support.
// Latency: mult/multu busy MULT_CYCLES, div/divu busy DIV_CYCLES; results on hi/lo the first non-busy cycle.
// Backpressure: busy is exported to the hazard unit; ops arriving while busy are ignored, req cancels the E-stage op.
// Ports: clk, reset (sync, active-high); a/b forwarded operands; mdu_op op code; req exception cancel;
//        busy in-flight flag; mdu_out mfhi/mflo read data; hi/lo committed registers for trace.
module e_mdu
   import e_mdu_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [3:0]  mdu_op,
   input  logic        req,
   output logic        busy,
   output logic [31:0] mdu_out,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   logic [CNT_W-1:0] cnt;
   logic [31:0]      hi_n;
   logic [31:0]      lo_n;
   logic             div_zero;

   // Arithmetic results, computed combinationally from the E-stage operands and
   // captured into the shadows only at the start edge.
   logic [63:0]        prod_s;
   logic [63:0]        prod_u;
   logic signed [31:0] a_s;
   logic signed [31:0] b_s;
   logic signed [31:0] quot_s;
   logic signed [31:0] rem_s;
   logic [31:0]        quot_u;
   logic [31:0]        rem_u;
   logic               b_zero;

   assign a_s    = $signed(a);
   assign b_s    = $signed(b);
   assign b_zero = (b == 32'd0);

   always_comb begin
      // Sign-extend to 64 bits and take the low half: identical to a signed 32x32 product.
      prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      prod_u = {32'd0, a} * {32'd0, b};
      quot_s = '0;
      rem_s  = '0;
      quot_u = '0;
      rem_u  = '0;
      // Guarded so a zero divisor never produces undefined values in the shadows.
      if (!b_zero) begin
         quot_s = a_s / b_s;   // truncates toward zero
         rem_s  = a_s % b_s;   // takes the sign of the dividend
         quot_u = a / b;
         rem_u  = a % b;
      end
   end

   assign busy = (cnt != '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt      <= '0;
         hi_n     <= '0;
         lo_n     <= '0;
         div_zero <= 1'b0;
         hi       <= '0;
         lo       <= '0;
      end else if (busy) begin
         // In-flight op runs to completion regardless of req or new ops in E.
         cnt <= cnt - CNT_W'(1);
         if (cnt == CNT_W'(1) && !div_zero) begin
            hi <= hi_n;
            lo <= lo_n;
         end
      end else if (!req) begin
         case (mdu_op)
            OP_MULT: begin
               hi_n     <= prod_s[63:32];
               lo_n     <= prod_s[31:0];
               div_zero <= 1'b0;
               cnt      <= CNT_W'(MULT_CYCLES);
            end
            OP_MULTU: begin
               hi_n     <= prod_u[63:32];
               lo_n     <= prod_u[31:0];
               div_zero <= 1'b0;
               cnt      <= CNT_W'(MULT_CYCLES);
            end
            OP_DIV: begin
               hi_n     <= rem_s;
               lo_n     <= quot_s;
               div_zero <= b_zero;
               cnt      <= CNT_W'(DIV_CYCLES);
            end
            OP_DIVU: begin
               hi_n     <= rem_u;
               lo_n     <= quot_u;
               div_zero <= b_zero;
               cnt      <= CNT_W'(DIV_CYCLES);
            end
            OP_MTHI: hi <= a;
            OP_MTLO: lo <= a;
            default: ;
         endcase
      end
   end

   // Reads always see committed HI/LO, never the shadows.
   always_comb begin
      mdu_out = '0;
      if (mdu_op == OP_MFHI) mdu_out = hi;
      else if (mdu_op == OP_MFLO) mdu_out = lo;
   end

endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: directed test of e_mdu with hand-computed expected values.
// Latency: inputs driven 1 time unit after the rising edge, outputs checked 1 unit later.
// Backpressure: n/a.
module tb_e_mdu;
   import e_mdu_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] a;
   logic [31:0] b;
   logic [3:0]  mdu_op;
   logic        req;
   logic        busy;
   logic [31:0] mdu_out;
   logic [31:0] hi;
   logic [31:0] lo;

   int vectors     = 0;
   int miscompares = 0;

   e_mdu dut (
      .clk     (clk),
      .reset   (reset),
      .a       (a),
      .b       (b),
      .mdu_op  (mdu_op),
      .req     (req),
      .busy    (busy),
      .mdu_out (mdu_out),
      .hi      (hi),
      .lo      (lo)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   // Issue a start op, then hold bop in E during the busy window and count busy cycles.
   // Returns in the first non-busy cycle with mdu_op back at NONE.
   task automatic run(input string tag, input logic [3:0] op, input logic [31:0] av,
                      input logic [31:0] bv, input int exp_n,
                      input logic [3:0] bop, input logic [31:0] bout);
      int n;
      mdu_op = op; a = av; b = bv;
      #1;
      chk({tag, "_start_busy"}, {31'd0, busy}, 32'd0);
      tick();
      mdu_op = bop; a = 32'h0000_0BAD; b = 32'd3;
      #1;
      chk({tag, "_busy_out"}, mdu_out, bout);
      n = 0;
      while (busy && n < 40) begin
         n++;
         tick();
      end
      mdu_op = OP_NONE;
      #1;
      chk({tag, "_busy_cycles"}, 32'(n), 32'(exp_n));
   endtask

   initial begin
      reset = 1'b1; a = '0; b = '0; mdu_op = OP_NONE; req = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      #1;
      chk("rst_hi", hi, 32'h0);
      chk("rst_lo", lo, 32'h0);
      chk("rst_busy", {31'd0, busy}, 32'h0);
      chk("rst_out", mdu_out, 32'h0);

      // -1 * 2 signed, then unsigned
      run("mult", OP_MULT, 32'hFFFF_FFFF, 32'd2, 5, OP_NONE, 32'h0);
      chk("mult_hi", hi, 32'hFFFF_FFFF);
      chk("mult_lo", lo, 32'hFFFF_FFFE);
      run("multu", OP_MULTU, 32'hFFFF_FFFF, 32'd2, 5, OP_NONE, 32'h0);
      chk("multu_hi", hi, 32'h0000_0001);
      chk("multu_lo", lo, 32'hFFFF_FFFE);

      // -7 / 2 signed; MFHI during busy must return the old HI (1), not the shadow
      run("div", OP_DIV, 32'hFFFF_FFF9, 32'd2, 10, OP_MFHI, 32'h0000_0001);
      chk("div_hi", hi, 32'hFFFF_FFFF);
      chk("div_lo", lo, 32'hFFFF_FFFD);
      mdu_op = OP_MFLO;
      #1;
      chk("div_mflo", mdu_out, 32'hFFFF_FFFD);

      run("divu", OP_DIVU, 32'd7, 32'd2, 10, OP_NONE, 32'h0);
      chk("divu_hi", hi, 32'd1);
      chk("divu_lo", lo, 32'd3);

      // MTHI then MFHI next cycle; MTLO
      mdu_op = OP_MTHI; a = 32'h11;
      tick();
      mdu_op = OP_MFHI; a = 32'h0;
      #1;
      chk("mthi_mfhi", mdu_out, 32'h11);
      mdu_op = OP_MTLO; a = 32'h22;
      tick();
      mdu_op = OP_NONE;
      #1;
      chk("mtlo_lo", lo, 32'h22);

      // Divide by zero: full busy window, HI/LO untouched
      run("divz", OP_DIVU, 32'd7, 32'd0, 10, OP_NONE, 32'h0);
      chk("divz_hi", hi, 32'h11);
      chk("divz_lo", lo, 32'h22);

      // req cancels a start and an mthi
      mdu_op = OP_MULT; a = 32'd3; b = 32'd4; req = 1'b1;
      tick();
      mdu_op = OP_NONE; req = 1'b0;
      #1;
      chk("req_mult_busy", {31'd0, busy}, 32'h0);
      tick();
      chk("req_mult_hi", hi, 32'h11);
      chk("req_mult_lo", lo, 32'h22);
      mdu_op = OP_MTHI; a = 32'hDEAD; req = 1'b1;
      tick();
      mdu_op = OP_NONE; req = 1'b0;
      #1;
      chk("req_mthi_hi", hi, 32'h11);

      mdu_op = OP_MTLO; a = 32'h1234;
      tick();
      mdu_op = OP_MFLO; a = 32'h0;
      #1;
      chk("mtlo_mflo", mdu_out, 32'h1234);
      mdu_op = OP_NONE;

      // MTHI issued while busy is ignored; 3*4 commits hi=0, lo=12
      run("mult34", OP_MULT, 32'd3, 32'd4, 5, OP_MTHI, 32'h0);
      chk("mult34_hi", hi, 32'h0);
      chk("mult34_lo", lo, 32'd12);

      // Reset in busy cycle 3 of a DIV aborts it (100/7 would commit hi=2, lo=14)
      mdu_op = OP_DIV; a = 32'd100; b = 32'd7;
      tick();
      mdu_op = OP_NONE;
      #1;
      chk("rdiv_busy1", {31'd0, busy}, 32'h1);
      tick();
      tick();
      chk("rdiv_busy3", {31'd0, busy}, 32'h1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      chk("rdiv_busy", {31'd0, busy}, 32'h0);
      chk("rdiv_hi", hi, 32'h0);
      chk("rdiv_lo", lo, 32'h0);
      repeat (12) tick();
      chk("rdiv_late_hi", hi, 32'h0);
      chk("rdiv_late_lo", lo, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
